rr_arbiter8: RTL and testbench



---
 rtl/rr_arbiter8.sv | 121 ++++++++++++
 tb/tb_rr_arbiter8.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - 8-requester round-robin arbiter with grant locking.
// The grant is registered and one-hot (or all-zero), and gnt_valid marks a
// live grant so a downstream one-hot encoder never mistakes an empty grant
// for index 0. An owner keeps its grant for as long as it keeps requesting.
// After each release the arbiter spends at least one cycle idle before it
// grants again, and the owner's successor gets first priority.
// Optional feature macro: RR_HOLD_LIMIT_EN. When it is defined, a grant is
// force-released after MAX_HOLD consecutive cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       en,
  output logic [7:0] gnt,
  output logic       gnt_valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_gnt;
  logic [7:0] w_nextGnt;
  logic [2:0] r_ptr;
  logic [2:0] w_nextPtr;
  logic [2:0] r_owner;
  logic [2:0] w_nextOwner;
  logic       w_found;
  logic [2:0] w_pick;
  logic       w_holdExpired;
  logic       w_release;

`ifdef RR_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_holdCnt;

  // Count grant cycles; the count is zero on every entry into GRANT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdCnt <= '0;
    end else if (r_state == IDLE) begin
      r_holdCnt <= '0;
    end else begin
      r_holdCnt <= r_holdCnt + 8'd1;
    end
  end

  assign w_holdExpired = (r_holdCnt == HOLD_LAST);
`else
  // There is no hold limit in this build. MAX_HOLD is at least 1, so this
  // expression is always false.
  assign w_holdExpired = (MAX_HOLD < 1);
`endif

  assign w_release = !req[r_owner] || w_holdExpired;

  // Find the first requester, scanning upward from the priority pointer with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && req[r_ptr + i[2:0]]) begin
        w_found = 1'b1;
        w_pick  = r_ptr + i[2:0];
      end
    end
  end

  // Next-state logic. New grants start only from IDLE, so there is always a bubble.
  always_comb begin
    w_nextState = r_state;
    w_nextGnt   = r_gnt;
    w_nextPtr   = r_ptr;
    w_nextOwner = r_owner;
    case (r_state)
      IDLE: begin
        w_nextGnt = '0;
        if (en && w_found) begin
          w_nextState = GRANT;
          w_nextGnt   = 8'b1 << w_pick;
          w_nextOwner = w_pick;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_nextState = IDLE;
          w_nextGnt   = '0;
          w_nextPtr   = r_owner + 3'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextGnt   = '0;
      end
    endcase
  end

  // State, grant and pointer registers. Reset clears them immediately, even mid-grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_nextState;
      r_gnt   <= w_nextGnt;
      r_ptr   <= w_nextPtr;
      r_owner <= w_nextOwner;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8 - directed and random checks of rr_arbiter8 against a
// behavioural model. The model tracks the owner index, the priority index
// and the number of grant cycles as plain integers.
module tb_rr_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       en;
  logic [7:0] gnt;
  logic       gnt_valid;

  int errors = 0;
  int checks = 0;

  int mOwner = -1;
  int mPtr   = 0;
  int mHeld  = 0;

  rr_arbiter8 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .en       (en),
    .gnt      (gnt),
    .gnt_valid(gnt_valid)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] expGnt();
    if (mOwner < 0) return 8'h00;
    return 8'(1 << mOwner);
  endfunction

  // Advance the model by one rising edge, given the inputs seen at that edge.
  task automatic modelEdge(input logic [7:0] r, input logic e);
    bit done;
    int c;
    if (mOwner < 0) begin
      done = 0;
      if (e && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          c = (mPtr + k) % 8;
          if (!done && r[c]) begin
            mOwner = c;
            mHeld  = 1;
            done   = 1;
          end
        end
      end
    end else begin
      done = (r[mOwner] == 1'b0);
`ifdef RR_HOLD_LIMIT_EN
      if (mHeld >= MAX_HOLD) done = 1;
`endif
      if (done) begin
        mPtr   = (mOwner + 1) % 8;
        mOwner = -1;
      end else begin
        mHeld++;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] eg;
    eg = expGnt();
    checks++;
    assert (gnt === eg) else begin
      errors++;
      $error("[TB] FAIL %s gnt observed=%h expected=%h", tag, gnt, eg);
    end
    checks++;
    assert (gnt_valid === (eg != 8'h00)) else begin
      errors++;
      $error("[TB] FAIL %s gnt_valid observed=%b expected=%b", tag, gnt_valid, (eg != 8'h00));
    end
  endtask

  task automatic expectConst(input string tag, input logic [7:0] val);
    checks++;
    assert (gnt === val) else begin
      errors++;
      $error("[TB] FAIL %s gnt observed=%h expected=%h", tag, gnt, val);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic e, input string tag);
    req = r;
    en  = e;
    @(posedge clk);
    modelEdge(r, e);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    rst = 1'b1;
    req = 8'h00;
    en  = 1'b0;
    #12;
    checkOutput("reset_state");
    rst = 1'b0;

    // 1: an asynchronous reset in the middle of a grant on bit 3
    applyStimulus(8'h08, 1'b1, "t1_grant3");
    expectConst("t1_grant3_const", 8'h08);
    applyStimulus(8'h08, 1'b1, "t1_hold3");
    #1 rst = 1'b1;
    #1;
    mOwner = -1; mPtr = 0; mHeld = 0;
    checkOutput("t1_async_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(8'hFF, 1'b1, "t1_after_reset");
    expectConst("t1_after_reset_const", 8'h01);
    applyStimulus(8'h00, 1'b1, "t1_release");

    // 2: a single request
    applyStimulus(8'h10, 1'b1, "t2_grant");
    expectConst("t2_grant_const", 8'h10);
    applyStimulus(8'h10, 1'b1, "t2_hold1");
    applyStimulus(8'h10, 1'b1, "t2_hold2");
    applyStimulus(8'h00, 1'b1, "t2_release");
    expectConst("t2_release_const", 8'h00);

    // 3: round-robin order with every requester active
    rst = 1'b1;
    #1;
    mOwner = -1; mPtr = 0; mHeld = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 9; g++) begin
      applyStimulus(8'hFF, 1'b1, "t3_grant");
      expectConst("t3_order", 8'(1 << (g % 8)));
      applyStimulus(8'hFF, 1'b1, "t3_hold");
      applyStimulus(8'hFF & ~8'(1 << (g % 8)), 1'b1, "t3_bubble");
      expectConst("t3_bubble_const", 8'h00);
    end

    // 4: wrap-around of the priority pointer
    applyStimulus(8'h80, 1'b1, "t4_grant7");
    applyStimulus(8'h00, 1'b1, "t4_release7");
    applyStimulus(8'h81, 1'b1, "t4_first");
    expectConst("t4_first_const", 8'h01);
    applyStimulus(8'h80, 1'b1, "t4_release0");
    applyStimulus(8'h81, 1'b1, "t4_second");
    expectConst("t4_second_const", 8'h80);
    applyStimulus(8'h00, 1'b1, "t4_release");

    // 5: enable gating
    for (int i = 0; i < 5; i++) applyStimulus(8'h04, 1'b0, "t5_gated");
    applyStimulus(8'h04, 1'b1, "t5_enabled");
    expectConst("t5_enabled_const", 8'h04);
    applyStimulus(8'h04, 1'b0, "t5_en_drop1");
    applyStimulus(8'h04, 1'b0, "t5_en_drop2");
    expectConst("t5_held_const", 8'h04);
    applyStimulus(8'h00, 1'b0, "t5_release");

`ifdef RR_HOLD_LIMIT_EN
    // 6: forced release at the hold limit
    rst = 1'b1;
    #1;
    mOwner = -1; mPtr = 0; mHeld = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h03, 1'b1, "t6_own0");
      expectConst("t6_own0_const", 8'h01);
    end
    applyStimulus(8'h03, 1'b1, "t6_bubble0");
    expectConst("t6_bubble0_const", 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h03, 1'b1, "t6_own1");
      expectConst("t6_own1_const", 8'h02);
    end
    applyStimulus(8'h03, 1'b1, "t6_bubble1");
    applyStimulus(8'h03, 1'b1, "t6_again0");
    expectConst("t6_again0_const", 8'h01);
    applyStimulus(8'h00, 1'b1, "t6_release");
`endif

    // Random traffic compared against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(8'($urandom), ($urandom_range(3, 0) != 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
